// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: default widths, the ALU writeback entry type
// and the ROB-relative age comparison used for redirect selection.
package exec_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_TAG_W = 6;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_PLEN  = 32;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] rob_tag;
    logic [DEF_XLEN-1:0]  result;
    logic                 is_mispred;
    logic [DEF_PLEN-1:0]  redirect_pc;
  } alu_wb_t;

  // Distance of a tag from the ROB head, modulo the tag space.
  function automatic logic [31:0] rob_age(input logic [31:0] tag,
                                          input logic [31:0] head,
                                          input int unsigned tag_w);
    logic [31:0] mask;
    mask = (32'd1 << tag_w) - 32'd1;
    return (tag - head) & mask;
  endfunction

  // True when tag a is strictly older (closer to the head) than tag b.
  function automatic logic is_older(input logic [31:0] a_tag,
                                    input logic [31:0] b_tag,
                                    input logic [31:0] head,
                                    input int unsigned tag_w);
    return rob_age(a_tag, head, tag_w) < rob_age(b_tag, head, tag_w);
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Single-clock DEPTH-entry FIFO of writeback entries with synchronous flush.
// Pointers carry a wrap bit above the index so full and empty are distinguishable.
module alu_wb_fifo
  import exec_pkg::*;
#(
  parameter type T     = alu_wb_t,
  parameter int  DEPTH = DEF_DEPTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     data_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_full;
  logic        w_empty;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i && !w_full)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop_i  && !w_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; an empty FIFO never exposes it, and leaving it out keeps it as plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_i && !w_full) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: rtl/alu_wb_collector.sv
// Collects ALU writebacks into per-port FIFOs, drains them round-robin to the ROB and
// tracks the oldest mispredict to raise a registered frontend redirect.
// Optional: define ALU_WB_BYPASS_EN for a 0-cycle path from an empty port to the wb outputs.
module alu_wb_collector
  import exec_pkg::*;
#(
  parameter int NUM_ALU = 2,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int XLEN    = DEF_XLEN,
  parameter int PC_W    = DEF_PLEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [TAG_W-1:0]        rob_head_i,
  input  logic [NUM_ALU-1:0]      alu_valid_i,
  output logic [NUM_ALU-1:0]      alu_ready_o,
  input  logic [NUM_ALU*TAG_W-1:0] alu_rob_tag_i,
  input  logic [NUM_ALU*XLEN-1:0] alu_result_i,
  input  logic [NUM_ALU-1:0]      alu_is_mispred_i,
  input  logic [NUM_ALU*PC_W-1:0] alu_redirect_pc_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [TAG_W-1:0]        wb_rob_tag_o,
  output logic [XLEN-1:0]         wb_result_o,
  output logic                    wb_is_mispred_o,
  output logic                    redirect_valid_o,
  output logic [PC_W-1:0]         redirect_pc_o
);

  localparam int RR_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]  result;
    logic             is_mispred;
    logic [PC_W-1:0]  redirect_pc;
  } entry_t;

  entry_t             w_in   [NUM_ALU];
  entry_t             w_head [NUM_ALU];
  entry_t             w_sel;
  logic [NUM_ALU-1:0] w_full;
  logic [NUM_ALU-1:0] w_empty;
  logic [NUM_ALU-1:0] w_accept;
  logic [NUM_ALU-1:0] w_push;
  logic [NUM_ALU-1:0] w_pop;
  logic [NUM_ALU-1:0] w_req;
  logic [RR_W-1:0]    w_grant;
  logic               w_grant_valid;
  logic               w_hs;

  logic               w_cand_valid;
  logic [TAG_W-1:0]   w_cand_tag;
  logic [PC_W-1:0]    w_cand_pc;
  logic               w_take;

  logic [RR_W-1:0]    r_rr_ptr;
  logic               r_trk_valid;
  logic [TAG_W-1:0]   r_trk_tag;
  logic               r_redirect_valid;
  logic [PC_W-1:0]    r_redirect_pc;

  // Flush discards every input in its cycle, so nothing is accepted then.
  assign w_accept    = alu_valid_i & ~w_full & {NUM_ALU{~flush_i}};
  assign alu_ready_o = ~w_full;

  for (genvar gi = 0; gi < NUM_ALU; gi++) begin : g_port
    assign w_in[gi] = '{rob_tag:     alu_rob_tag_i[gi*TAG_W +: TAG_W],
                        result:      alu_result_i[gi*XLEN +: XLEN],
                        is_mispred:  alu_is_mispred_i[gi],
                        redirect_pc: alu_redirect_pc_i[gi*PC_W +: PC_W]};

    alu_wb_fifo #(
      .T     (entry_t),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (w_push[gi]),
      .pop_i   (w_pop[gi]),
      .data_i  (w_in[gi]),
      .data_o  (w_head[gi]),
      .full_o  (w_full[gi]),
      .empty_o (w_empty[gi])
    );
  end

`ifdef ALU_WB_BYPASS_EN
  // An empty port may present its live input; it is only stored if the ROB does not take it.
  assign w_req  = ~w_empty | alu_valid_i;
  assign w_sel  = w_empty[w_grant] ? w_in[w_grant] : w_head[w_grant];
  assign w_push = w_accept & ~(w_pop & w_empty);
`else
  assign w_req  = ~w_empty;
  assign w_sel  = w_head[w_grant];
  assign w_push = w_accept;
`endif

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_ALU) idx = idx - NUM_ALU;
      if (!w_grant_valid && w_req[RR_W'(idx)]) begin
        w_grant_valid = 1'b1;
        w_grant       = RR_W'(idx);
      end
    end
  end

  assign w_hs = w_grant_valid && wb_ready_i && !flush_i;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      w_pop[i] = w_hs && (w_grant == RR_W'(i));
    end
  end

  assign wb_valid_o      = w_grant_valid;
  assign wb_rob_tag_o    = w_grant_valid ? w_sel.rob_tag    : '0;
  assign wb_result_o     = w_grant_valid ? w_sel.result     : '0;
  assign wb_is_mispred_o = w_grant_valid ? w_sel.is_mispred : 1'b0;

  // Grant holds under backpressure because the pointer only moves on a handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (flush_i) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_grant == RR_W'(NUM_ALU - 1)) ? '0 : w_grant + RR_W'(1);
    end
  end

  // Oldest accepted mispredict this cycle; strict compare lets the lower index win a tie.
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand_tag   = '0;
    w_cand_pc    = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      if (w_accept[i] && w_in[i].is_mispred &&
          (!w_cand_valid ||
           is_older(32'(w_in[i].rob_tag), 32'(w_cand_tag), 32'(rob_head_i), TAG_W))) begin
        w_cand_valid = 1'b1;
        w_cand_tag   = w_in[i].rob_tag;
        w_cand_pc    = w_in[i].redirect_pc;
      end
    end
  end

  assign w_take = w_cand_valid &&
                  (!r_trk_valid ||
                   is_older(32'(w_cand_tag), 32'(r_trk_tag), 32'(rob_head_i), TAG_W));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_trk_valid      <= 1'b0;
      r_trk_tag        <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else if (flush_i) begin
      r_trk_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else begin
      r_redirect_valid <= w_take;
      if (w_take) begin
        r_trk_valid   <= 1'b1;
        r_trk_tag     <= w_cand_tag;
        r_redirect_pc <= w_cand_pc;
      end
    end
  end

  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_redirect_pc;

  // The issue side must never present a result to a full port.
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (alu_valid_i & ~alu_ready_o) == '0);

endmodule

// File: tb/tb_alu_wb_collector.sv
// Scoreboard bench for alu_wb_collector: per-port expected queues, a round-robin
// reference for drain order, and a reference redirect tracker.
module tb_alu_wb_collector;
  import exec_pkg::*;

  localparam int NA = 2;
  localparam int DP = 4;
  localparam int TW = 6;
  localparam int XL = 32;
  localparam int PW = 32;

  typedef struct {
    logic [TW-1:0] tag;
    logic [XL-1:0] res;
    logic          mis;
  } exp_t;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               flush_i;
  logic [TW-1:0]      rob_head_i;
  logic [NA-1:0]      alu_valid_i;
  logic [NA-1:0]      alu_ready_o;
  logic [NA*TW-1:0]   alu_rob_tag_i;
  logic [NA*XL-1:0]   alu_result_i;
  logic [NA-1:0]      alu_is_mispred_i;
  logic [NA*PW-1:0]   alu_redirect_pc_i;
  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [TW-1:0]      wb_rob_tag_o;
  logic [XL-1:0]      wb_result_o;
  logic               wb_is_mispred_o;
  logic               redirect_valid_o;
  logic [PW-1:0]      redirect_pc_o;

  int n_checks = 0;
  int n_errors = 0;

  exp_t          exp_q [NA][$];
  int            m_rr;
  logic          m_trk_v;
  logic [TW-1:0] m_trk_tag;
  logic          m_redir_v;
  logic [PW-1:0] m_redir_pc;

  always #5 clk_i = ~clk_i;

  alu_wb_collector #(
    .NUM_ALU (NA), .DEPTH (DP), .TAG_W (TW), .XLEN (XL), .PC_W (PW)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .rob_head_i        (rob_head_i),
    .alu_valid_i       (alu_valid_i),
    .alu_ready_o       (alu_ready_o),
    .alu_rob_tag_i     (alu_rob_tag_i),
    .alu_result_i      (alu_result_i),
    .alu_is_mispred_i  (alu_is_mispred_i),
    .alu_redirect_pc_i (alu_redirect_pc_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_rob_tag_o      (wb_rob_tag_o),
    .wb_result_o       (wb_result_o),
    .wb_is_mispred_o   (wb_is_mispred_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] age(input logic [TW-1:0] t);
    return t - rob_head_i;
  endfunction

  task automatic clear_inputs();
    alu_valid_i       = '0;
    alu_is_mispred_i  = '0;
    alu_rob_tag_i     = '0;
    alu_result_i      = '0;
    alu_redirect_pc_i = '0;
    flush_i           = 1'b0;
  endtask

  task automatic drive(input int p, input logic [TW-1:0] tag, input logic [XL-1:0] res,
                       input logic mis, input logic [PW-1:0] pc);
    alu_valid_i[p]            = 1'b1;
    alu_rob_tag_i[p*TW +: TW] = tag;
    alu_result_i[p*XL +: XL]  = res;
    alu_is_mispred_i[p]       = mis;
    alu_redirect_pc_i[p*PW +: PW] = pc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) exp_q[i].delete();
    m_rr       = 0;
    m_trk_v    = 1'b0;
    m_trk_tag  = '0;
    m_redir_v  = 1'b0;
    m_redir_pc = '0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    exp_t          e;
    int            p;
    int            best;
    logic [TW-1:0] btag;
    logic [PW-1:0] bpc;
    logic          any;
    #2;
    for (int i = 0; i < NA; i++)
      check($sformatf("ready%0d", i), 64'(alu_ready_o[i]), 64'(exp_q[i].size() < DP));
    any = 1'b0;
    p   = 0;
    for (int k = 0; k < NA; k++) begin
      if (!any && exp_q[(m_rr + k) % NA].size() != 0) begin
        any = 1'b1;
        p   = (m_rr + k) % NA;
      end
    end
    check("wb_valid", 64'(wb_valid_o), 64'(any));
    if (any) begin
      e = exp_q[p][0];
      check("wb_tag",  64'(wb_rob_tag_o),    64'(e.tag));
      check("wb_res",  64'(wb_result_o),     64'(e.res));
      check("wb_mis",  64'(wb_is_mispred_o), 64'(e.mis));
      if (wb_ready_i && !flush_i) begin
        void'(exp_q[p].pop_front());
        m_rr = (p + 1) % NA;
      end
    end else begin
      check("wb_tag_idle", 64'(wb_rob_tag_o), 64'd0);
      check("wb_res_idle", 64'(wb_result_o),  64'd0);
    end
    if (flush_i) begin
      for (int i = 0; i < NA; i++) exp_q[i].delete();
      m_rr      = 0;
      m_trk_v   = 1'b0;
      m_redir_v = 1'b0;
    end else begin
      best = -1;
      btag = '0;
      bpc  = '0;
      for (int i = 0; i < NA; i++) begin
        if (alu_valid_i[i]) begin
          e.tag = alu_rob_tag_i[i*TW +: TW];
          e.res = alu_result_i[i*XL +: XL];
          e.mis = alu_is_mispred_i[i];
          exp_q[i].push_back(e);
          if (e.mis && (best < 0 || age(e.tag) < age(btag))) begin
            best = i;
            btag = e.tag;
            bpc  = alu_redirect_pc_i[i*PW +: PW];
          end
        end
      end
      m_redir_v = 1'b0;
      if (best >= 0 && (!m_trk_v || age(btag) < age(m_trk_tag))) begin
        m_trk_v    = 1'b1;
        m_trk_tag  = btag;
        m_redir_v  = 1'b1;
        m_redir_pc = bpc;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    check("redir_v",  64'(redirect_valid_o), 64'(m_redir_v));
    check("redir_pc", 64'(redirect_pc_o),    64'(m_redir_pc));
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_ni     = 1'b0;
    wb_ready_i = 1'b1;
    rob_head_i = '0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk_i);
    check("rst_wb_valid", 64'(wb_valid_o),       64'd0);
    check("rst_redir_v",  64'(redirect_valid_o), 64'd0);
    check("rst_redir_pc", 64'(redirect_pc_o),    64'd0);
    rst_ni = 1'b1;
    idle(1);

    // Single push, one-cycle latency.
    drive(0, 6'd5, 32'h1234, 1'b0, 32'h0);
    cycle();
    idle(3);

    // Both ports streaming; drain alternates between ports.
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      drive(0, 6'(10 + k), 32'hA000 + 32'(k), 1'b0, 32'h0);
      drive(1, 6'(20 + k), 32'hB000 + 32'(k), 1'b0, 32'h0);
      cycle();
    end
    idle(6);

    // Fill port 0 under backpressure, drain, then repeat to wrap the pointers.
    for (int r = 0; r < 2; r++) begin
      wb_ready_i = 1'b0;
      for (int k = 0; k < DP; k++) begin
        clear_inputs();
        drive(0, 6'(30 + 8*r + k), 32'hC000 + 32'(8*r + k), 1'b0, 32'h0);
        cycle();
      end
      idle(2);
      wb_ready_i = 1'b1;
      idle(DP + 1);
    end

    // Oldest mispredict relative to a wrapped ROB head.
    rob_head_i = 6'd60;
    clear_inputs();
    drive(0, 6'd2,  32'h1, 1'b1, 32'h100);
    drive(1, 6'd62, 32'h2, 1'b1, 32'h200);
    cycle();
    idle(1);
    drive(0, 6'd1, 32'h3, 1'b1, 32'h300);
    cycle();
    idle(1);
    drive(1, 6'd61, 32'h4, 1'b1, 32'h440);
    cycle();
    idle(3);

    // Flush with three queued entries, a live tracker and a coincident push.
    wb_ready_i = 1'b0;
    clear_inputs();
    drive(0, 6'd3, 32'h5, 1'b0, 32'h0);
    drive(1, 6'd4, 32'h6, 1'b0, 32'h0);
    cycle();
    clear_inputs();
    drive(0, 6'd8, 32'h7, 1'b0, 32'h0);
    cycle();
    clear_inputs();
    drive(0, 6'd7, 32'h8, 1'b1, 32'h400);
    flush_i = 1'b1;
    cycle();
    clear_inputs();
    drive(1, 6'd50, 32'h9, 1'b1, 32'h500);
    cycle();
    wb_ready_i = 1'b1;
    idle(3);

    // Asynchronous reset mid-drain with two entries still queued.
    wb_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      drive(0, 6'(16 + k), 32'hD000 + 32'(k), 1'b0, 32'h0);
      cycle();
    end
    wb_ready_i = 1'b1;
    idle(1);
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    check("mid_rst_wb_valid", 64'(wb_valid_o),       64'd0);
    check("mid_rst_wb_tag",   64'(wb_rob_tag_o),     64'd0);
    check("mid_rst_redir_v",  64'(redirect_valid_o), 64'd0);
    check("mid_rst_redir_pc", 64'(redirect_pc_o),    64'd0);
    check("mid_rst_ready",    64'(alu_ready_o),      64'(2'b11));
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
